// File: rtl/tdm_demux64.sv
// tdm_demux64: 1-to-64 serial demultiplexer with two ways to load the outputs.
// In IDLE, a manual write strobe drives one selected output bit.
// An automatic capture frame collects 64 qualified serial bits into a shadow
// register and then transfers all 64 bits to the outputs in a single step.
// Every output is registered.
module tdm_demux64 #(
    parameter bit CLR_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic [5:0]  sel,
    input  logic        wr_en,
    input  logic        start,
    input  logic        din_valid,
    input  logic        abort,
    output logic [63:0] out,
    output logic        busy,
    output logic        done,
    output logic [5:0]  slot,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] out_q, out_d;
    logic [63:0] shadow_q, shadow_d;
    logic [5:0]  slot_q, slot_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    // State register: reset returns the FSM to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In CAPTURE, abort takes priority over a valid sample.
    // DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (din_valid && (slot_q == 6'd63)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values. The final sample is merged into the
    // outputs on the same edge that enters DONE, so the new outputs, done and
    // the incremented frame count are all visible during the DONE cycle.
    always_comb begin
        out_d       = out_q;
        shadow_d    = shadow_q;
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Start wins over a simultaneous manual write.
                    slot_d = 6'd0;
                    if (CLR_ON_START) begin
                        shadow_d = 64'd0;
                    end else begin
                        shadow_d = shadow_q;
                    end
                end else if (wr_en) begin
                    out_d[sel] = din;
                end else begin
                    out_d = out_q;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    // The partial frame is dropped; the outputs are left unchanged.
                    slot_d = 6'd0;
                end else if (din_valid) begin
                    shadow_d[slot_q] = din;
                    slot_d           = slot_q + 6'd1;
                    if (slot_q == 6'd63) begin
                        out_d       = shadow_d;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        out_d = out_q;
                    end
                end else begin
                    slot_d = slot_q;
                end
            end
            ST_DONE: begin
                // Hold for one cycle; abort, start and wr_en are ignored here.
                slot_d = slot_q;
            end
            default: begin
                slot_d = 6'd0;
            end
        endcase
    end

    // Datapath registers: reset clears all visible state asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 64'd0;
            shadow_q    <= 64'd0;
            slot_q      <= 6'd0;
            frame_cnt_q <= 8'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            shadow_q    <= shadow_d;
            slot_q      <= slot_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign slot      = slot_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux64.sv
// Directed self-checking bench for tdm_demux64.
module tb_tdm_demux64;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic [5:0]  sel;
    logic        wr_en;
    logic        start;
    logic        din_valid;
    logic        abort;
    logic [63:0] out;
    logic        busy;
    logic        done;
    logic [5:0]  slot;
    logic [7:0]  frame_cnt;

    integer checks = 0;
    integer errors = 0;
    logic [63:0] pat;
    logic [63:0] exp_out;

    tdm_demux64 dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .wr_en(wr_en),
        .start(start), .din_valid(din_valid), .abort(abort), .out(out),
        .busy(busy), .done(done), .slot(slot), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [63:0] data);
        start = 1'b1;
        step();
        start = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            din = data[i];
            step();
        end
        din_valid = 1'b0;
        din = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b0; sel = 6'd0; wr_en = 1'b0;
        start = 1'b0; din_valid = 1'b0; abort = 1'b0;
        step();
        step();
        checks++;
        if (out !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || slot !== 6'd0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: out=%h busy=%b done=%b slot=%0d fc=%0d required all zero",
                     out, busy, done, slot, frame_cnt);
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_manual();
        exp_out = 64'd0;
        for (int k = 0; k < 64; k++) begin
            sel = k[5:0]; din = 1'b1; wr_en = 1'b1;
            step();
            exp_out[k] = 1'b1;
            checks++;
            if (out !== exp_out || busy !== 1'b0) begin
                errors++;
                $display("FAIL manual_write k=%0d: out=%h busy=%b required out=%h busy=0", k, out, busy, exp_out);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || slot !== 6'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: busy=%b slot=%0d done=%b required 1/0/0", busy, slot, done);
        end
        // start and wr_en during capture must not disturb the outputs
        for (int i = 0; i < 64; i++) begin
            din = pat[i]; din_valid = 1'b1; wr_en = 1'b1; start = 1'b1; sel = 6'd3;
            step();
            if (i < 63) begin
                checks++;
                if (slot !== 6'(i + 1) || done !== 1'b0 || out !== exp_out || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_capture i=%0d: slot=%0d done=%b out=%h required slot=%0d done=0 out=%h",
                             i, slot, done, out, i + 1, exp_out);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || out !== pat || frame_cnt !== 8'd1 || slot !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_done: done=%b out=%h fc=%0d slot=%0d busy=%b required 1/%h/1/0/1",
                     done, out, frame_cnt, slot, busy, pat);
        end
        // DONE ignores abort, start and wr_en
        din_valid = 1'b0; abort = 1'b1; start = 1'b1; wr_en = 1'b1; din = 1'b0;
        step();
        abort = 1'b0; start = 1'b0; wr_en = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== pat || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_after_done: done=%b busy=%b out=%h fc=%0d required 0/0/%h/1",
                     done, busy, out, frame_cnt, pat);
        end
    endtask

    task automatic test_gapped();
        // Clear bits 0 and 63 first so the frame has something visible to restore.
        sel = 6'd0; din = 1'b0; wr_en = 1'b1;
        step();
        sel = 6'd63;
        step();
        wr_en = 1'b0;
        exp_out = pat;
        exp_out[0] = 1'b0;
        exp_out[63] = 1'b0;
        checks++;
        if (out !== exp_out) begin
            errors++;
            $display("FAIL gapped_preclear: out=%h required %h", out, exp_out);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            din = ~pat[i]; din_valid = 1'b0;
            step();
            checks++;
            if (slot !== 6'(i) || done !== 1'b0 || out !== exp_out) begin
                errors++;
                $display("FAIL gapped_hold i=%0d: slot=%0d done=%b out=%h required slot=%0d done=0 out=%h",
                         i, slot, done, out, i, exp_out);
            end
            din = pat[i]; din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || out !== pat || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL gapped_done: done=%b out=%h fc=%0d required 1/%h/2", done, out, frame_cnt, pat);
        end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = ~pat[i];
            step();
        end
        checks++;
        if (slot !== 6'd20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: slot=%0d busy=%b required 20/1", slot, busy);
        end
        abort = 1'b1; din = 1'b1;
        step();
        abort = 1'b0; din_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || slot !== 6'd0 || out !== pat || frame_cnt !== 8'd2 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b slot=%0d out=%h fc=%0d done=%b required 0/0/%h/2/0",
                     busy, slot, out, frame_cnt, done, pat);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet i=%0d: done=%b busy=%b required 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 37; i++) begin
            din = pat[i];
            step();
        end
        checks++;
        if (slot !== 6'd37) begin
            errors++;
            $display("FAIL areset_pre: slot=%0d required 37", slot);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 64'd0 || slot !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL areset_immediate: out=%h slot=%0d busy=%b done=%b fc=%0d required all zero",
                     out, slot, busy, done, frame_cnt);
        end
        din_valid = 1'b0;
        step();
        #3 rst_n = 1'b1;
        step();
        run_frame(pat);
        checks++;
        if (out !== pat || frame_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_recover: out=%h fc=%0d busy=%b required %h/1/0", out, frame_cnt, busy, pat);
        end
    endtask

    task automatic test_wrap_priority();
        for (int f = 0; f < 254; f++) begin
            run_frame(64'd0);
        end
        checks++;
        if (frame_cnt !== 8'd255 || out !== 64'd0) begin
            errors++;
            $display("FAIL wrap_255: fc=%0d out=%h required 255/0", frame_cnt, out);
        end
        run_frame(pat);
        checks++;
        if (frame_cnt !== 8'd0 || out !== pat) begin
            errors++;
            $display("FAIL wrap_0: fc=%0d out=%h required 0/%h", frame_cnt, out, pat);
        end
        // pat bit 16 is 0; the write must be dropped because start wins
        start = 1'b1; wr_en = 1'b1; sel = 6'd16; din = 1'b1;
        step();
        start = 1'b0; wr_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || out !== pat || slot !== 6'd0) begin
            errors++;
            $display("FAIL start_priority: busy=%b out=%h slot=%0d required 1/%h/0", busy, out, slot, pat);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== pat || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL final_abort: busy=%b out=%h fc=%0d required 0/%h/0", busy, out, frame_cnt, pat);
        end
    endtask

    initial begin
        pat = 64'hA5A5_0F0F_3C3C_FFFF;
        test_reset();
        test_manual();
        test_frame();
        test_gapped();
        test_abort();
        test_async_reset();
        test_wrap_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
